sc_level_progress_counter: RTL
==============================

Name: sc_level_progress_counter

Overview:
- Datapath companion to the level state machine: owns the current-level register, the in-level progress counter and the level-dependent game tick (T0).
- Feeds the state machine its CurrentLevel, LvlProgressCount and T0 inputs.
- Consumes the state machine's active-low LevelFinished, ProgressUpCount and FinishedGame strobes.
- Sits directly upstream/downstream of the level FSM in a closed loop; all outputs are registered.

Parameters:
- LEVEL_WIDTH, 3, width of level code (0 = no level, 1..3 = playing, 4 = end).
- PROGRESS_WIDTH, 5, width of progress counter.
- PROGRESS_TARGET, 20, saturation value of progress; the FSM flags level finished at this value.
- TICK_WIDTH, 26, width of tick divider counter.
- TICK_PERIOD_L1, 50000000, clocks per T0 tick in level 1.
- TICK_PERIOD_L2, 25000000, clocks per T0 tick in level 2.
- TICK_PERIOD_L3, 12500000, clocks per T0 tick in level 3.

Ports:
- SC_LEVEL_PROGRESS_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LEVEL_PROGRESS_RESET_InLow  in  1  reset; synchronous, active-low.
- SC_LEVEL_PROGRESS_Start_InLow  in  1  game-start request, active-low, level-sensitive.
- SC_LEVEL_PROGRESS_LevelFinished_InLow  in  1  from FSM, low while the level goal is met.
- SC_LEVEL_PROGRESS_ProgressUpCount_InLow  in  1  from FSM, one-cycle low = add one progress step.
- SC_LEVEL_PROGRESS_FinishedGame_InLow  in  1  from FSM, low = game over, freeze.
- SC_LEVEL_PROGRESS_CurrentLevel_Out  out  LEVEL_WIDTH  level code to FSM and display.
- SC_LEVEL_PROGRESS_LvlProgressCount_Out  out  PROGRESS_WIDTH  progress to FSM and display.
- SC_LEVEL_PROGRESS_T0_OutLow  out  1  one-cycle low tick pulse to FSM.
- SC_LEVEL_PROGRESS_LevelChange_OutLow  out  1  one-cycle low pulse when the level increments.

Behaviour:
- Reset: one clock, synchronous, active-low; sampled on the rising clock edge only.
  - Reset values: CurrentLevel = 0, LvlProgressCount = 0, T0_OutLow = 1, LevelChange_OutLow = 1.
  - Internal state: tick counter = 0, LevelFinished history register = 1.
  - Reset asserted mid-game clears all state at that edge and overrides every other input.
- Level register:
  - Level 0 with Start_InLow = 0 at an edge: level becomes 1.
  - Otherwise level 0 holds.
  - Levels 1..3: a falling edge of LevelFinished_InLow (history = 1, current = 0) increments the level by 1 at that edge, saturating at 4.
  - LevelFinished held low for many cycles gives exactly one increment.
  - Level 4 holds until reset.
- LevelChange_OutLow: driven 0 for the single cycle following any level increment, including the 0 to 1 start; otherwise 1.
- Progress counter:
  - ProgressUpCount_InLow = 0 at an edge while level is 1..3: progress increments by 1, saturating at PROGRESS_TARGET.
  - Every level increment clears progress to 0 at the same edge.
  - Simultaneous level increment and progress strobe: the level increment wins and progress becomes 0.
  - Progress is ignored in levels 0 and 4.
- Tick timer:
  - Runs only while level is 1..3 and FinishedGame_InLow = 1.
  - Period P is selected by level: TICK_PERIOD_L1, TICK_PERIOD_L2 or TICK_PERIOD_L3.
  - Counter counts 0..P-1. At the edge where count = P-1: count wraps to 0 and T0_OutLow becomes 0 for exactly one cycle. At all other edges T0_OutLow = 1.
  - First tick after a reload appears P cycles later.
  - A level change reloads the counter to 0 and forces T0_OutLow = 1 at that edge.
  - In level 0, level 4, or with FinishedGame_InLow = 0: counter holds and T0_OutLow = 1.
- Freeze: FinishedGame_InLow = 0 freezes level, progress and timer. Only reset recovers.
- Width rules:
  - Unsigned arithmetic throughout; no wrap-around on level or progress.
  - Period comparison is done at TICK_WIDTH; each period must be at least 2 and must fit in TICK_WIDTH.

Decomposition:
- Shared package (sc_game_pkg) holds:
  - level code constants: LEVEL_NONE = 0, LEVEL_1 = 1, LEVEL_2 = 2, LEVEL_3 = 3, LEVEL_END = 4;
  - LEVEL_WIDTH and PROGRESS_WIDTH, shared with the level FSM.
- One sub-module, sc_tick_timer:
  - inputs: enable, reload, period;
  - output: active-low registered tick;
  - instantiated once, with period muxed by level in the parent.

Test Plan:
- Use periods 8/6/4 and PROGRESS_TARGET 20.
- Reset low 2 cycles, then Start low 1 cycle -> level 1 next edge, LevelChange low 1 cycle, first T0 low pulse 8 cycles later, then every 8 cycles.
- Level 1, 25 single-cycle ProgressUpCount strobes -> progress stops at 20, never 21 or 0.
- Hold LevelFinished low 10 cycles in level 1 -> level 2 exactly once, progress 0, T0 period 6, one LevelChange pulse.
- LevelFinished falling edge in the same cycle as a ProgressUpCount strobe -> level +1, progress 0.
- Drive three level finishes from level 1 -> level 4; further LevelFinished edges do nothing; T0 stays 1.
- FinishedGame low at timer count 3 -> counter, level and progress frozen; then reset low 1 edge mid-game -> all outputs return to reset values.

Source files
------------

// File: rtl/sc_game_pkg.sv
// Shared game definitions: level codes and datapath widths used by the level FSM and its
// progress/tick companion.
package sc_game_pkg;

  localparam int unsigned LEVEL_WIDTH    = 3;
  localparam int unsigned PROGRESS_WIDTH = 5;

  typedef logic [LEVEL_WIDTH-1:0]    level_t;
  typedef logic [PROGRESS_WIDTH-1:0] progress_t;

  localparam level_t LEVEL_NONE = level_t'(0);
  localparam level_t LEVEL_1    = level_t'(1);
  localparam level_t LEVEL_2    = level_t'(2);
  localparam level_t LEVEL_3    = level_t'(3);
  localparam level_t LEVEL_END  = level_t'(4);

  // True while a level is actually being played (1..3).
  function automatic logic level_playing(input level_t lvl);
    return (lvl >= LEVEL_1) && (lvl <= LEVEL_3);
  endfunction

endpackage

// File: rtl/sc_level_progress_counter_if.sv
// Strobe/status bundle between the level FSM (master) and the level/progress counter (slave).
interface sc_level_progress_counter_if;
  import sc_game_pkg::*;

  logic      SC_LEVEL_PROGRESS_Start_InLow;
  logic      SC_LEVEL_PROGRESS_LevelFinished_InLow;
  logic      SC_LEVEL_PROGRESS_ProgressUpCount_InLow;
  logic      SC_LEVEL_PROGRESS_FinishedGame_InLow;
  level_t    SC_LEVEL_PROGRESS_CurrentLevel_Out;
  progress_t SC_LEVEL_PROGRESS_LvlProgressCount_Out;
  logic      SC_LEVEL_PROGRESS_T0_OutLow;
  logic      SC_LEVEL_PROGRESS_LevelChange_OutLow;

  modport master (
    output SC_LEVEL_PROGRESS_Start_InLow,
    output SC_LEVEL_PROGRESS_LevelFinished_InLow,
    output SC_LEVEL_PROGRESS_ProgressUpCount_InLow,
    output SC_LEVEL_PROGRESS_FinishedGame_InLow,
    input  SC_LEVEL_PROGRESS_CurrentLevel_Out,
    input  SC_LEVEL_PROGRESS_LvlProgressCount_Out,
    input  SC_LEVEL_PROGRESS_T0_OutLow,
    input  SC_LEVEL_PROGRESS_LevelChange_OutLow
  );

  modport slave (
    input  SC_LEVEL_PROGRESS_Start_InLow,
    input  SC_LEVEL_PROGRESS_LevelFinished_InLow,
    input  SC_LEVEL_PROGRESS_ProgressUpCount_InLow,
    input  SC_LEVEL_PROGRESS_FinishedGame_InLow,
    output SC_LEVEL_PROGRESS_CurrentLevel_Out,
    output SC_LEVEL_PROGRESS_LvlProgressCount_Out,
    output SC_LEVEL_PROGRESS_T0_OutLow,
    output SC_LEVEL_PROGRESS_LevelChange_OutLow
  );

endinterface

// File: rtl/sc_tick_timer.sv
// Free-running divider producing a one-cycle active-low tick every 'period' enabled clocks.
module sc_tick_timer #(
  parameter int unsigned TICK_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  reload,
  input  logic [TICK_WIDTH-1:0] period,
  output logic                  tick_n
);

  logic [TICK_WIDTH-1:0] count_q;

  // Reload dominates; a disabled timer holds its count and never ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_n  <= 1'b1;
    end else if (reload) begin
      count_q <= '0;
      tick_n  <= 1'b1;
    end else if (enable && (count_q == (period - TICK_WIDTH'(1)))) begin
      count_q <= '0;
      tick_n  <= 1'b0;
    end else begin
      if (enable) begin
        count_q <= count_q + TICK_WIDTH'(1);
      end
      tick_n <= 1'b1;
    end
  end

endmodule

// File: rtl/sc_level_progress_counter.sv
// Level register, in-level progress counter and level-paced T0 tick feeding the level FSM.
module sc_level_progress_counter
  import sc_game_pkg::*;
#(
  parameter int unsigned PROGRESS_TARGET = 20,
  parameter int unsigned TICK_WIDTH      = 26,
  parameter int unsigned TICK_PERIOD_L1  = 50000000,
  parameter int unsigned TICK_PERIOD_L2  = 25000000,
  parameter int unsigned TICK_PERIOD_L3  = 12500000
) (
  input  logic                         SC_LEVEL_PROGRESS_CLOCK_50,
  input  logic                         SC_LEVEL_PROGRESS_RESET_InLow,
  sc_level_progress_counter_if.slave   bus
);

  level_t                level_q, level_d;
  progress_t             progress_q, progress_d;
  logic                  level_change_q;
  logic                  finished_hist_q;
  logic                  level_inc_c;
  logic                  progress_step_c;
  logic                  timer_run_c;
  logic [TICK_WIDTH-1:0] period_c;
  logic                  tick_n;

  // State register
  always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50) begin
    if (!SC_LEVEL_PROGRESS_RESET_InLow) begin
      level_q         <= LEVEL_NONE;
      progress_q      <= '0;
      level_change_q  <= 1'b1;
      finished_hist_q <= 1'b1;
    end else begin
      level_q         <= level_d;
      progress_q      <= progress_d;
      level_change_q  <= ~level_inc_c;
      finished_hist_q <= bus.SC_LEVEL_PROGRESS_LevelFinished_InLow;
    end
  end

  // Next state: a level increment always clears progress, even against a progress strobe
  always_comb begin
    level_d    = level_q;
    progress_d = progress_q;
    if (level_inc_c) begin
      progress_d = '0;
      if (level_q == LEVEL_NONE) begin
        level_d = LEVEL_1;
      end else if (level_q == LEVEL_3) begin
        level_d = LEVEL_END;
      end else begin
        level_d = level_q + level_t'(1);
      end
    end else if (progress_step_c) begin
      progress_d = progress_q + progress_t'(1);
    end
  end

  // Control decode; FinishedGame low freezes every update
  always_comb begin
    level_inc_c     = 1'b0;
    progress_step_c = 1'b0;
    timer_run_c     = 1'b0;
    if (bus.SC_LEVEL_PROGRESS_FinishedGame_InLow) begin
      if (level_q == LEVEL_NONE) begin
        level_inc_c = ~bus.SC_LEVEL_PROGRESS_Start_InLow;
      end else if (level_playing(level_q)) begin
        level_inc_c     = finished_hist_q & ~bus.SC_LEVEL_PROGRESS_LevelFinished_InLow;
        progress_step_c = ~bus.SC_LEVEL_PROGRESS_ProgressUpCount_InLow &&
                          (progress_q < PROGRESS_WIDTH'(PROGRESS_TARGET));
        timer_run_c     = 1'b1;
      end
    end

    case (level_q)
      LEVEL_2: period_c = TICK_WIDTH'(TICK_PERIOD_L2);
      LEVEL_3: period_c = TICK_WIDTH'(TICK_PERIOD_L3);
      default: period_c = TICK_WIDTH'(TICK_PERIOD_L1);
    endcase
  end

  sc_tick_timer #(
    .TICK_WIDTH (TICK_WIDTH)
  ) u_tick_timer (
    .clk    (SC_LEVEL_PROGRESS_CLOCK_50),
    .rst_n  (SC_LEVEL_PROGRESS_RESET_InLow),
    .enable (timer_run_c),
    .reload (level_inc_c),
    .period (period_c),
    .tick_n (tick_n)
  );

  assign bus.SC_LEVEL_PROGRESS_CurrentLevel_Out     = level_q;
  assign bus.SC_LEVEL_PROGRESS_LvlProgressCount_Out = progress_q;
  assign bus.SC_LEVEL_PROGRESS_T0_OutLow            = tick_n;
  assign bus.SC_LEVEL_PROGRESS_LevelChange_OutLow   = level_change_q;

endmodule
